// File: rtl/multiplier_hd_pkg.sv
// Shared definitions for the online signed-digit multiplier.
//   - borrow-save digit codes (value = bit0 - bit1)
//   - online delay of the multiplier
//   - operation phase enum
//   - digit decode helper returning -1/0/+1
package multiplier_hd_pkg;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b10;

  localparam int DELTA = 3;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    FLUSH
  } state_t;

  // Code 11 decodes to zero, like 00.
  function automatic logic signed [1:0] dig_decode(input logic [1:0] d);
    logic signed [1:0] v;
    case (d)
      DIG_POS: v = 2'sb01;
      DIG_NEG: v = 2'sb11;
      default: v = 2'sb00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/online_mult_selm.sv
// Output digit selection for the online multiplier.
// Ports:
//   i_v_top : top 5 bits of the residual estimate V (sign, 2 integer, 2 fractional)
//   o_p     : selected product digit, borrow-save code (never 11)
module online_mult_selm
  import multiplier_hd_pkg::*;
(
  input  logic [4:0] i_v_top,
  output logic [1:0] o_p
);

  // Truncated estimate in units of 1/4: +1 at >= 1/2, -1 below -1/2.
  logic signed [4:0] w_v_hat;
  assign w_v_hat = $signed(i_v_top);

  always_comb begin
    o_p = DIG_ZERO;
    if (w_v_hat >= 5'sd2)
      o_p = DIG_POS;
    else if (w_v_hat < -5'sd2)
      o_p = DIG_NEG;
  end

endmodule

// File: rtl/multiplier_hd.sv
// Radix-2 online (MSD-first) signed-digit multiplier, online delay 3.
// Consumes one x and one y digit per step and emits one product digit per
// step once the delay has elapsed; N+3 steps per operation.
// Ports:
//   clk, asyn_reset              : clock, async active-high reset
//   x_value/data_x_vld/data_x_rdy: x operand digit stream
//   y_value/data_y_vld/data_y_rdy: y operand digit stream
//   p_value/data_out_vld/data_out_rdy : product digit stream
//
// state | meaning
// INIT  | j = 0..2, consume digits, build residual, no output
// RUN   | j = 3..N-1, consume digits and emit product digits
// FLUSH | j = N..N+2, zero inputs, emit the remaining product digits
module multiplier_hd
  import multiplier_hd_pkg::*;
#(
  parameter int N = 16
) (
  input  logic       clk,
  input  logic       asyn_reset,
  input  logic [1:0] x_value,
  input  logic [1:0] y_value,
  output logic [1:0] p_value,
  input  logic       data_x_vld,
  output logic       data_x_rdy,
  input  logic       data_y_vld,
  output logic       data_y_rdy,
  output logic       data_out_vld,
  input  logic       data_out_rdy
);

  localparam int XW = N + 2;
  localparam int WW = N + 6;
  localparam int JW = $clog2(N + 3);
  // 1.0 in the residual format (N+3 fractional bits).
  localparam logic signed [WW-1:0] W_ONE = {3'b001, {(N + 3){1'b0}}};

  state_t                 r_state;
  logic [JW-1:0]          r_j;
  logic signed [XW-1:0]   r_x;
  logic signed [XW-1:0]   r_y;
  logic signed [WW-1:0]   r_w;
  logic [1:0]             r_p;
  logic                   r_out_vld;

  logic                   w_in_phase;
  logic                   w_out_free;
  logic                   w_fire;
  logic signed [1:0]      w_xd;
  logic signed [1:0]      w_yd;
  logic signed [1:0]      w_pd;
  logic signed [XW-1:0]   w_wt;
  logic signed [XW-1:0]   w_x_new;
  logic signed [XW-1:0]   w_y_new;
  logic signed [WW-1:0]   w_x_ext;
  logic signed [WW-1:0]   w_y_ext;
  logic signed [WW-1:0]   w_v;
  logic signed [WW-1:0]   w_w_next;
  logic [1:0]             w_p;

  assign p_value      = r_p;
  assign data_out_vld = r_out_vld;

  assign w_in_phase = (r_state == INIT) || (r_state == RUN);
  assign w_out_free = !r_out_vld || data_out_rdy;
  // Held low during reset even though the registered terms already look idle.
  assign data_x_rdy = w_in_phase && w_out_free && !asyn_reset;
  assign data_y_rdy = data_x_rdy;
  assign w_fire     = w_in_phase ? (data_x_vld && data_y_vld && w_out_free) : w_out_free;

  always_comb begin
    w_xd = w_in_phase ? dig_decode(x_value) : 2'sb00;
    w_yd = w_in_phase ? dig_decode(y_value) : 2'sb00;

    // Weight 2^-(j+1) of the incoming digit, in X/Y LSB units (2^-N).
    w_wt = '0;
    if (r_j < JW'(N))
      w_wt = {{(XW - 1){1'b0}}, 1'b1} << (JW'(N - 1) - r_j);

    w_y_new = r_y;
    if (w_yd == 2'sb01)
      w_y_new = r_y + w_wt;
    else if (w_yd == 2'sb11)
      w_y_new = r_y - w_wt;

    w_x_new = r_x;
    if (w_xd == 2'sb01)
      w_x_new = r_x + w_wt;
    else if (w_xd == 2'sb11)
      w_x_new = r_x - w_wt;

    // X/Y carry N fractional bits, W carries N+3; the 2^-3 scaling of the
    // cross terms is therefore just a sign extension, no shift.
    w_x_ext = {{(WW - XW){r_x[XW-1]}}, r_x};
    w_y_ext = {{(WW - XW){w_y_new[XW-1]}}, w_y_new};

    w_v = r_w <<< 1;
    if (w_xd == 2'sb01)
      w_v = w_v + w_y_ext;
    else if (w_xd == 2'sb11)
      w_v = w_v - w_y_ext;
    if (w_yd == 2'sb01)
      w_v = w_v + w_x_ext;
    else if (w_yd == 2'sb11)
      w_v = w_v - w_x_ext;

    w_pd = dig_decode(w_p);
    w_w_next = w_v;
    if (w_pd == 2'sb01)
      w_w_next = w_v - W_ONE;
    else if (w_pd == 2'sb11)
      w_w_next = w_v + W_ONE;
  end

  online_mult_selm u_selm (
    .i_v_top (w_v[WW-1:WW-5]),
    .o_p     (w_p)
  );

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      r_state   <= INIT;
      r_j       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_w       <= '0;
      r_p       <= DIG_ZERO;
      r_out_vld <= 1'b0;
    end else if (w_fire) begin
      r_x <= w_x_new;
      r_y <= w_y_new;
      r_j <= r_j + 1'b1;
      case (r_state)
        INIT: begin
          r_w       <= w_v;
          r_out_vld <= 1'b0;
          if (r_j == JW'(DELTA - 1))
            r_state <= RUN;
        end
        RUN: begin
          r_w       <= w_w_next;
          r_p       <= w_p;
          r_out_vld <= 1'b1;
          if (r_j == JW'(N - 1))
            r_state <= FLUSH;
        end
        FLUSH: begin
          r_p       <= w_p;
          r_out_vld <= 1'b1;
          if (r_j == JW'(N + DELTA - 1)) begin
            // Last step: clear the datapath so the next pair starts clean.
            r_state <= INIT;
            r_j     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
          end else begin
            r_w <= w_w_next;
          end
        end
        default: r_state <= INIT;
      endcase
    end else if (data_out_rdy) begin
      r_out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplier_hd.sv
module tb_multiplier_hd;

  localparam int N = 16;
  localparam longint LIM = 64'sd65536;

  logic       clk = 1'b0;
  logic       asyn_reset;
  logic [1:0] x_value;
  logic [1:0] y_value;
  logic [1:0] p_value;
  logic       data_x_vld;
  logic       data_x_rdy;
  logic       data_y_vld;
  logic       data_y_rdy;
  logic       data_out_vld;
  logic       data_out_rdy;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] xs [N];
  logic [1:0] ys [N];

  multiplier_hd #(.N(N)) dut (
    .clk          (clk),
    .asyn_reset   (asyn_reset),
    .x_value      (x_value),
    .y_value      (y_value),
    .p_value      (p_value),
    .data_x_vld   (data_x_vld),
    .data_x_rdy   (data_x_rdy),
    .data_y_vld   (data_y_vld),
    .data_y_rdy   (data_y_rdy),
    .data_out_vld (data_out_vld),
    .data_out_rdy (data_out_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint dval(input logic [1:0] d);
    if (d == 2'b01) return 1;
    if (d == 2'b10) return -1;
    return 0;
  endfunction

  // Operand value in units of 2^-N.
  function automatic longint seq_val(input bit use_y);
    longint v = 0;
    for (int i = 0; i < N; i++)
      v += dval(use_y ? ys[i] : xs[i]) * (longint'(1) <<< (N - 1 - i));
    return v;
  endfunction

  function automatic void rand_ops();
    for (int i = 0; i < N; i++) begin
      xs[i] = 2'($urandom_range(0, 3));
      ys[i] = 2'($urandom_range(0, 3));
    end
  endfunction

  function automatic void half_ops(input logic [1:0] y0);
    for (int i = 0; i < N; i++) begin
      xs[i] = 2'b00;
      ys[i] = 2'b00;
    end
    xs[0] = 2'b01;
    ys[0] = y0;
  endfunction

  // Drives one operation, collects the N product digits; psum in 2^-N units.
  task automatic run_op(input int stall_at, input int stall_len,
                        input int ydrop_at, input int ydrop_len,
                        output longint psum);
    int ix, nout, cyc;
    bit prev_hold, saw11;
    logic [1:0] prev_p;
    ix = 0; nout = 0; cyc = 0; psum = 0; prev_hold = 0; saw11 = 0; prev_p = 2'b00;
    while (nout < N && cyc < 300) begin
      @(negedge clk);
      data_out_rdy = !(cyc >= stall_at && cyc < stall_at + stall_len);
      data_x_vld   = (ix < N);
      data_y_vld   = (ix < N) && !(cyc >= ydrop_at && cyc < ydrop_at + ydrop_len);
      x_value      = (ix < N) ? xs[ix] : 2'b00;
      y_value      = (ix < N) ? ys[ix] : 2'b00;
      #1;
      if (prev_hold) begin
        check("stall_p_held", 64'(p_value), 64'(prev_p));
        check("stall_vld_held", 64'(data_out_vld), 64'd1);
      end
      if (!data_out_rdy && data_out_vld) begin
        check("stall_rdy_low", 64'({data_x_rdy, data_y_rdy}), 64'd0);
        prev_hold = 1;
        prev_p = p_value;
      end else begin
        prev_hold = 0;
      end
      if (data_x_vld && data_y_vld && data_x_rdy) ix++;
      if (data_out_vld && data_out_rdy) begin
        psum += dval(p_value) <<< (N - 1 - nout);
        if (p_value == 2'b11) saw11 = 1;
        nout++;
      end
      cyc++;
    end
    data_out_rdy = 1'b1;
    data_x_vld = 1'b0;
    data_y_vld = 1'b0;
    check("op_digit_count", 64'(nout), 64'(N));
    check("no_code_11", 64'(saw11), 64'd0);
  endtask

  initial begin
    longint p, p_ref, err, xv, yv;
    int nout_z, ix;

    asyn_reset = 1'b1;
    x_value = 2'b00; y_value = 2'b00;
    data_x_vld = 1'b1; data_y_vld = 1'b1; data_out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_vld", 64'(data_out_vld), 64'd0);
    check("rst_p_value", 64'(p_value), 64'd0);
    check("rst_rdy", 64'({data_x_rdy, data_y_rdy}), 64'd0);
    data_x_vld = 1'b0; data_y_vld = 1'b0;
    @(negedge clk);
    asyn_reset = 1'b0;

    // All-zero operands at full throughput: timing of rdy and out_vld.
    nout_z = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      data_x_vld = (c < N); data_y_vld = (c < N);
      x_value = 2'b00; y_value = 2'b00; data_out_rdy = 1'b1;
      #1;
      check("zero_rdy", 64'(data_x_rdy), 64'((c < N) || (c >= N + 3)));
      check("zero_out_vld", 64'(data_out_vld), 64'((c >= 4) && (c <= N + 3)));
      if (data_out_vld) begin
        check("zero_digit", 64'(p_value), 64'd0);
        nout_z++;
      end
    end
    check("zero_count", 64'(nout_z), 64'(N));
    data_x_vld = 1'b0; data_y_vld = 1'b0;

    half_ops(2'b01);
    run_op(1000, 0, 1000, 0, p);
    check("half_times_half", 64'(p), 64'(64'sd16384));
    half_ops(2'b10);
    run_op(1000, 0, 1000, 0, p);
    check("half_times_neg_half", 64'(p), 64'(-64'sd16384));

    for (int t = 0; t < 1000; t++) begin
      rand_ops();
      run_op(int'($urandom_range(0, 25)), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 25)), int'($urandom_range(0, 4)), p);
      xv = seq_val(0); yv = seq_val(1);
      err = xv * yv - p * 65536;
      if (!(err <= LIM && err >= -LIM))
        $display("op %0d: x=%0d y=%0d p=%0d", t, xv, yv, p);
      check("rand_err_bound", 64'(err <= LIM && err >= -LIM), 64'd1);
    end

    // Output stall and y-valid drop must not change the result.
    rand_ops();
    run_op(1000, 0, 1000, 0, p_ref);
    xv = seq_val(0); yv = seq_val(1);
    err = xv * yv - p_ref * 65536;
    check("ref_err_bound", 64'(err <= LIM && err >= -LIM), 64'd1);
    run_op(8, 5, 1000, 0, p);
    check("stall_same_result", 64'(p), 64'(p_ref));
    run_op(1000, 0, 6, 3, p);
    check("ydrop_same_result", 64'(p), 64'(p_ref));

    // Reset asserted in the middle of FLUSH.
    rand_ops();
    ix = 0;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      data_out_rdy = 1'b1;
      data_x_vld = (ix < N); data_y_vld = (ix < N);
      x_value = (ix < N) ? xs[ix] : 2'b00;
      y_value = (ix < N) ? ys[ix] : 2'b00;
      #1;
      if (data_x_vld && data_y_vld && data_x_rdy) ix++;
    end
    check("flush_vld_before_rst", 64'(data_out_vld), 64'd1);
    check("flush_rdy_before_rst", 64'(data_x_rdy), 64'd0);
    asyn_reset = 1'b1;
    #1;
    check("midrst_out_vld", 64'(data_out_vld), 64'd0);
    check("midrst_p_value", 64'(p_value), 64'd0);
    check("midrst_rdy", 64'({data_x_rdy, data_y_rdy}), 64'd0);
    data_x_vld = 1'b0; data_y_vld = 1'b0;
    @(negedge clk);
    asyn_reset = 1'b0;
    half_ops(2'b01);
    run_op(1000, 0, 1000, 0, p);
    check("post_rst_half_sq", 64'(p), 64'(64'sd16384));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
